// File: rtl/chess_pkg.sv
// Shared chess board / sprite definitions used by the VGA sprite scheduler.
package chess_pkg;

   localparam int unsigned SQ_SIZE      = 55;
   localparam int unsigned BOARD_N      = 8;
   localparam int unsigned SPRITE_WORDS = 3025;

   localparam int unsigned COORD_W = 10;
   localparam int unsigned ADDR_W  = $clog2(SPRITE_WORDS);
   localparam int unsigned CODE_W  = 4;
   localparam int unsigned CNT_W   = $clog2(BOARD_N);
   localparam int unsigned SQIDX_W = 2 * CNT_W;
   localparam int unsigned OFF_W   = $clog2(SQ_SIZE);
   localparam int unsigned PAL_W   = 2;

   typedef enum logic [CODE_W-1:0] {
      PC_EMPTY    = 4'h0,
      PC_W_PAWN   = 4'h1,
      PC_W_KNIGHT = 4'h2,
      PC_W_BISHOP = 4'h3,
      PC_W_ROOK   = 4'h4,
      PC_W_QUEEN  = 4'h5,
      PC_W_KING   = 4'h6,
      PC_B_PAWN   = 4'h9,
      PC_B_KNIGHT = 4'hA,
      PC_B_BISHOP = 4'hB,
      PC_B_ROOK   = 4'hC,
      PC_B_QUEEN  = 4'hD,
      PC_B_KING   = 4'hE
   } piece_t;

   // Type bits 0 and 7 carry no sprite, whatever the colour bit says.
   function automatic logic piece_valid(input logic [CODE_W-1:0] code);
      return (code[2:0] != 3'd0) && (code[2:0] != 3'd7);
   endfunction

endpackage

// File: rtl/board_pos_tracker.sv
// Incremental beam-to-board tracker: square row/col, texel x offset and row base
// address for the current pixel, updated without multiply or divide.
module board_pos_tracker
   import chess_pkg::*;
#(
   parameter logic [COORD_W-1:0] BOARD_X0 = 10'd100,
   parameter logic [COORD_W-1:0] BOARD_Y0 = 10'd20,
   parameter int unsigned        SQ       = SQ_SIZE
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [COORD_W-1:0] i_draw_x,
   input  logic [COORD_W-1:0] i_draw_y,
   output logic [CNT_W-1:0]   o_col_c,
   output logic [CNT_W-1:0]   o_row_c,
   output logic [OFF_W-1:0]   o_x_off_c,
   output logic [ADDR_W-1:0]  o_y_base_c,
   output logic               o_in_x_c,
   output logic               o_in_y_c
);

   localparam logic [COORD_W-1:0] X_END    = COORD_W'(32'(BOARD_X0) + BOARD_N * SQ);
   localparam logic [COORD_W-1:0] Y_END    = COORD_W'(32'(BOARD_Y0) + BOARD_N * SQ);
   localparam logic [OFF_W-1:0]   OFF_LAST = OFF_W'(SQ - 1);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BOARD_N - 1);
   localparam logic [ADDR_W-1:0]  SQ_STEP  = ADDR_W'(SQ);

   logic [COORD_W-1:0] r_draw_y;
   logic [CNT_W-1:0]   r_col;
   logic [CNT_W-1:0]   r_row;
   logic [OFF_W-1:0]   r_x_off;
   logic [OFF_W-1:0]   r_y_off;
   logic [ADDR_W-1:0]  r_y_base;
   logic               r_y_valid;

   logic [CNT_W-1:0]   w_col;
   logic [CNT_W-1:0]   w_row;
   logic [OFF_W-1:0]   w_x_off;
   logic [OFF_W-1:0]   w_y_off;
   logic [ADDR_W-1:0]  w_y_base;
   logic               w_line_chg;
   logic               w_y_start;
   logic               w_y_valid;
   logic               w_in_x;
   logic               w_in_y;

   // Row tracking is only trusted once a top-of-board line has been seen after reset.
   always_comb begin
      w_line_chg = (i_draw_y != r_draw_y);
      w_y_start  = w_line_chg && (i_draw_y == BOARD_Y0);
      w_y_valid  = w_y_start || r_y_valid;
      w_in_x     = (i_draw_x >= BOARD_X0) && (i_draw_x < X_END);
      w_in_y     = (i_draw_y >= BOARD_Y0) && (i_draw_y < Y_END) && w_y_valid;
   end

   // Column walk: restart at the board's left edge, saturate past the right edge.
   always_comb begin
      w_col   = r_col;
      w_x_off = r_x_off;
      if (i_draw_x == BOARD_X0) begin
         w_col   = '0;
         w_x_off = '0;
      end else if (r_x_off == OFF_LAST) begin
         if (r_col != CNT_LAST) begin
            w_col   = r_col + CNT_W'(1);
            w_x_off = '0;
         end
      end else begin
         w_x_off = r_x_off + OFF_W'(1);
      end
   end

   // Row walk: one step per new line inside the board; y_base tracks y_off*SQ.
   always_comb begin
      w_row    = r_row;
      w_y_off  = r_y_off;
      w_y_base = r_y_base;
      if (w_y_start) begin
         w_row    = '0;
         w_y_off  = '0;
         w_y_base = '0;
      end else if (w_line_chg && w_in_y) begin
         if (r_y_off == OFF_LAST) begin
            if (r_row != CNT_LAST) begin
               w_row    = r_row + CNT_W'(1);
               w_y_off  = '0;
               w_y_base = '0;
            end
         end else begin
            w_y_off  = r_y_off + OFF_W'(1);
            w_y_base = r_y_base + SQ_STEP;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_draw_y  <= '0;
         r_col     <= '0;
         r_row     <= '0;
         r_x_off   <= '0;
         r_y_off   <= '0;
         r_y_base  <= '0;
         r_y_valid <= 1'b0;
      end else begin
         r_draw_y  <= i_draw_y;
         r_col     <= w_col;
         r_row     <= w_row;
         r_x_off   <= w_x_off;
         r_y_off   <= w_y_off;
         r_y_base  <= w_y_base;
         r_y_valid <= w_y_valid;
      end
   end

   assign o_col_c    = w_col;
   assign o_row_c    = w_row;
   assign o_x_off_c  = w_x_off;
   assign o_y_base_c = w_y_base;
   assign o_in_x_c   = w_in_x;
   assign o_in_y_c   = w_in_y;

endmodule

// File: rtl/board_sprite_sched.sv
// Per-pixel sprite scheduler: board RAM lookup, sprite ROM addressing and a
// fixed 3-cycle pipeline delivering palette index and overlay flags.
module board_sprite_sched
   import chess_pkg::*;
#(
   parameter logic [COORD_W-1:0] BOARD_X0 = 10'd100,
   parameter logic [COORD_W-1:0] BOARD_Y0 = 10'd20,
   parameter int unsigned        SQ       = SQ_SIZE
) (
   input  logic               vga_clk,
   input  logic               reset,
   input  logic [COORD_W-1:0] DrawX,
   input  logic [COORD_W-1:0] DrawY,
   input  logic               blank,
   output logic [SQIDX_W-1:0] sq_index,
   input  logic [CODE_W-1:0]  piece_code,
   output logic [CODE_W-1:0]  rom_sel,
   output logic [ADDR_W-1:0]  rom_address,
   input  logic [PAL_W-1:0]   rom_q,
   output logic [PAL_W-1:0]   pix_index,
   output logic [CODE_W-1:0]  pix_piece,
   output logic               pix_opaque,
   output logic               pix_in_board,
   output logic               pix_light,
   output logic               pix_blank
);

   logic [CNT_W-1:0]   w_col;
   logic [CNT_W-1:0]   w_row;
   logic [OFF_W-1:0]   w_x_off;
   logic [ADDR_W-1:0]  w_y_base;
   logic               w_in_x;
   logic               w_in_y;

   logic [SQIDX_W-1:0] r_sq_index;
   logic [ADDR_W-1:0]  r_addr;
   logic               r_in_board1;
   logic               r_light1;
   logic               r_blank1;

   piece_t             r_rom_sel;
   logic [ADDR_W-1:0]  r_rom_address;
   logic               r_in_board2;
   logic               r_light2;
   logic               r_blank2;

   logic [PAL_W-1:0]   r_pix_index;
   piece_t             r_pix_piece;
   logic               r_pix_opaque;
   logic               r_pix_in_board;
   logic               r_pix_light;
   logic               r_pix_blank;

   board_pos_tracker #(
      .BOARD_X0 (BOARD_X0),
      .BOARD_Y0 (BOARD_Y0),
      .SQ       (SQ)
   ) u_pos (
      .i_clk      (vga_clk),
      .i_rst      (reset),
      .i_draw_x   (DrawX),
      .i_draw_y   (DrawY),
      .o_col_c    (w_col),
      .o_row_c    (w_row),
      .o_x_off_c  (w_x_off),
      .o_y_base_c (w_y_base),
      .o_in_x_c   (w_in_x),
      .o_in_y_c   (w_in_y)
   );

   // Stage 1: board RAM address and texel address for the current pixel.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_sq_index  <= '0;
         r_addr      <= '0;
         r_in_board1 <= 1'b0;
         r_light1    <= 1'b0;
         r_blank1    <= 1'b0;
      end else begin
         r_sq_index  <= {w_row, w_col};
         r_addr      <= w_y_base + ADDR_W'(w_x_off);
         r_in_board1 <= w_in_x && w_in_y;
         r_light1    <= ~(w_row[0] ^ w_col[0]);
         r_blank1    <= blank;
      end
   end

   // Stage 2: piece code from the board RAM selects the sprite ROM.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_rom_sel     <= PC_EMPTY;
         r_rom_address <= '0;
         r_in_board2   <= 1'b0;
         r_light2      <= 1'b0;
         r_blank2      <= 1'b0;
      end else begin
         r_rom_sel     <= (r_in_board1 && piece_valid(piece_code)) ? piece_t'(piece_code)
                                                                   : PC_EMPTY;
         r_rom_address <= r_addr;
         r_in_board2   <= r_in_board1;
         r_light2      <= r_light1;
         r_blank2      <= r_blank1;
      end
   end

   // Stage 3: ROM texel; palette index 0 is the transparent colour.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_pix_index    <= '0;
         r_pix_piece    <= PC_EMPTY;
         r_pix_opaque   <= 1'b0;
         r_pix_in_board <= 1'b0;
         r_pix_light    <= 1'b0;
         r_pix_blank    <= 1'b0;
      end else begin
         r_pix_index    <= r_in_board2 ? rom_q : '0;
         r_pix_piece    <= r_in_board2 ? r_rom_sel : PC_EMPTY;
         r_pix_opaque   <= r_in_board2 && r_blank2 && (r_rom_sel != PC_EMPTY)
                           && (rom_q != PAL_W'(0));
         r_pix_in_board <= r_in_board2;
         r_pix_light    <= r_light2;
         r_pix_blank    <= r_blank2;
      end
   end

   assign sq_index     = r_sq_index;
   assign rom_sel      = r_rom_sel;
   assign rom_address  = r_rom_address;
   assign pix_index    = r_pix_index;
   assign pix_piece    = r_pix_piece;
   assign pix_opaque   = r_pix_opaque;
   assign pix_in_board = r_pix_in_board;
   assign pix_light    = r_pix_light;
   assign pix_blank    = r_pix_blank;

endmodule

// File: tb/tb_board_sprite_sched.sv
// Directed bench for board_sprite_sched with negedge-read board RAM and sprite ROM models.
module tb_board_sprite_sched;

   logic        vga_clk = 1'b0;
   logic        reset;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        blank;
   logic [5:0]  sq_index;
   logic [3:0]  piece_code;
   logic [3:0]  rom_sel;
   logic [11:0] rom_address;
   logic [1:0]  rom_q;
   logic [1:0]  pix_index;
   logic [3:0]  pix_piece;
   logic        pix_opaque;
   logic        pix_in_board;
   logic        pix_light;
   logic        pix_blank;

   logic [3:0]  board_mem [64];
   logic [1:0]  rom_fill;
   int          total;
   int          bad;

   board_sprite_sched #(
      .BOARD_X0 (10'd100),
      .BOARD_Y0 (10'd20),
      .SQ       (55)
   ) dut (
      .vga_clk      (vga_clk),
      .reset        (reset),
      .DrawX        (DrawX),
      .DrawY        (DrawY),
      .blank        (blank),
      .sq_index     (sq_index),
      .piece_code   (piece_code),
      .rom_sel      (rom_sel),
      .rom_address  (rom_address),
      .rom_q        (rom_q),
      .pix_index    (pix_index),
      .pix_piece    (pix_piece),
      .pix_opaque   (pix_opaque),
      .pix_in_board (pix_in_board),
      .pix_light    (pix_light),
      .pix_blank    (pix_blank)
   );

   always #5 vga_clk = ~vga_clk;

   always @(negedge vga_clk) begin
      piece_code <= board_mem[sq_index];
      rom_q      <= rom_fill;
   end

   task automatic tick(input logic [9:0] x, input logic [9:0] y, input logic b);
      DrawX = x;
      DrawY = y;
      blank = b;
      @(posedge vga_clk);
      #1;
   endtask

   task automatic sweep(input int y, input int x0, input int x1, input logic b);
      for (int x = x0; x <= x1; x++) tick(10'(x), 10'(y), b);
   endtask

   task automatic skip_lines(input int y0, input int y1);
      for (int y = y0; y <= y1; y++) tick(10'd0, 10'(y), 1'b0);
   endtask

   task automatic test_reset;
      tick(10'd0, 10'd19, 1'b1);
      sweep(20, 100, 102, 1'b1);
      total++;
      if (pix_in_board !== 1'b1) begin
         bad++; $display("FAIL pre_reset_in_board got=%0b exp=1", pix_in_board);
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if ({sq_index, rom_sel, rom_address, pix_index, pix_piece,
           pix_opaque, pix_in_board, pix_light, pix_blank} !== 34'd0) begin
         bad++;
         $display("FAIL reset_outputs got sq=%0d sel=%0d addr=%0d idx=%0d pc=%0d op=%0b ib=%0b lt=%0b bl=%0b exp all 0",
                  sq_index, rom_sel, rom_address, pix_index, pix_piece,
                  pix_opaque, pix_in_board, pix_light, pix_blank);
      end
      tick(10'd103, 10'd20, 1'b1);
      reset = 1'b0;
      sweep(50, 100, 102, 1'b1);
      total++;
      if (pix_in_board !== 1'b0) begin
         bad++; $display("FAIL midframe_in_board got=%0b exp=0", pix_in_board);
      end
   endtask

   task automatic test_origin;
      tick(10'd0, 10'd19, 1'b1);
      tick(10'd100, 10'd20, 1'b1);
      total++;
      if (sq_index !== 6'd0) begin
         bad++; $display("FAIL origin_sq got=%0d exp=0", sq_index);
      end
      tick(10'd101, 10'd20, 1'b1);
      total++;
      if (rom_sel !== 4'd9 || rom_address !== 12'd0) begin
         bad++; $display("FAIL origin_rom got sel=%0d addr=%0d exp sel=9 addr=0", rom_sel, rom_address);
      end
      tick(10'd102, 10'd20, 1'b1);
      total++;
      if (pix_piece !== 4'd9 || pix_in_board !== 1'b1 || pix_light !== 1'b1 ||
          pix_blank !== 1'b1 || pix_index !== 2'd1 || pix_opaque !== 1'b1) begin
         bad++;
         $display("FAIL origin_pix got pc=%0d ib=%0b lt=%0b bl=%0b idx=%0d op=%0b exp 9 1 1 1 1 1",
                  pix_piece, pix_in_board, pix_light, pix_blank, pix_index, pix_opaque);
      end
   endtask

   task automatic test_col_wrap;
      sweep(20, 103, 154, 1'b1);
      total++;
      if (sq_index !== 6'd0) begin
         bad++; $display("FAIL wrap_sq154 got=%0d exp=0", sq_index);
      end
      tick(10'd155, 10'd20, 1'b1);
      total++;
      if (sq_index !== 6'd1 || rom_address !== 12'd54) begin
         bad++; $display("FAIL wrap_155 got sq=%0d addr=%0d exp sq=1 addr=54", sq_index, rom_address);
      end
      tick(10'd156, 10'd20, 1'b1);
      total++;
      if (rom_address !== 12'd0) begin
         bad++; $display("FAIL wrap_addr155 got=%0d exp=0", rom_address);
      end
      tick(10'd157, 10'd20, 1'b1);
      total++;
      if (pix_light !== 1'b0) begin
         bad++; $display("FAIL wrap_light got=%0b exp=0", pix_light);
      end
   endtask

   task automatic test_rows;
      tick(10'd100, 10'd21, 1'b1);
      tick(10'd101, 10'd21, 1'b1);
      total++;
      if (rom_address !== 12'd55) begin
         bad++; $display("FAIL row_addr21 got=%0d exp=55", rom_address);
      end
      skip_lines(22, 74);
      tick(10'd100, 10'd75, 1'b1);
      total++;
      if (sq_index !== 6'd8) begin
         bad++; $display("FAIL row_sq75 got=%0d exp=8", sq_index);
      end
      tick(10'd101, 10'd75, 1'b1);
      total++;
      if (rom_address !== 12'd0) begin
         bad++; $display("FAIL row_addr75 got=%0d exp=0", rom_address);
      end
      skip_lines(76, 458);
      sweep(459, 100, 539, 1'b1);
      total++;
      if (sq_index !== 6'd63) begin
         bad++; $display("FAIL last_sq got=%0d exp=63", sq_index);
      end
      tick(10'd540, 10'd459, 1'b1);
      total++;
      if (rom_address !== 12'd3024 || rom_sel !== 4'd14) begin
         bad++; $display("FAIL last_rom got addr=%0d sel=%0d exp addr=3024 sel=14", rom_address, rom_sel);
      end
      tick(10'd541, 10'd459, 1'b1);
      total++;
      if (pix_piece !== 4'd14 || pix_in_board !== 1'b1 || pix_light !== 1'b1 || rom_sel !== 4'd0) begin
         bad++;
         $display("FAIL last_pix got pc=%0d ib=%0b lt=%0b sel540=%0d exp 14 1 1 0",
                  pix_piece, pix_in_board, pix_light, rom_sel);
      end
      tick(10'd542, 10'd459, 1'b1);
      total++;
      if (pix_in_board !== 1'b0 || pix_piece !== 4'd0 || pix_index !== 2'd0 || pix_opaque !== 1'b0) begin
         bad++;
         $display("FAIL outside_pix got ib=%0b pc=%0d idx=%0d op=%0b exp all 0",
                  pix_in_board, pix_piece, pix_index, pix_opaque);
      end
   endtask

   task automatic test_empty;
      rom_fill = 2'd2;
      tick(10'd0, 10'd19, 1'b1);
      sweep(20, 100, 157, 1'b1);
      total++;
      if (pix_opaque !== 1'b0 || pix_piece !== 4'd0 || pix_in_board !== 1'b1 || pix_index !== 2'd2) begin
         bad++;
         $display("FAIL empty_sq got op=%0b pc=%0d ib=%0b idx=%0d exp 0 0 1 2",
                  pix_opaque, pix_piece, pix_in_board, pix_index);
      end
   endtask

   task automatic test_opacity;
      rom_fill = 2'd0;
      tick(10'd0, 10'd19, 1'b1);
      sweep(20, 100, 220, 1'b1);
      total++;
      if (pix_piece !== 4'd6 || pix_opaque !== 1'b0) begin
         bad++; $display("FAIL clear_texel got pc=%0d op=%0b exp pc=6 op=0", pix_piece, pix_opaque);
      end
      rom_fill = 2'd3;
      tick(10'd0, 10'd19, 1'b1);
      sweep(20, 100, 220, 1'b1);
      total++;
      if (pix_opaque !== 1'b1 || pix_index !== 2'd3) begin
         bad++; $display("FAIL solid_texel got op=%0b idx=%0d exp op=1 idx=3", pix_opaque, pix_index);
      end
      tick(10'd0, 10'd19, 1'b0);
      sweep(20, 100, 220, 1'b0);
      total++;
      if (pix_opaque !== 1'b0 || pix_blank !== 1'b0 || pix_piece !== 4'd6) begin
         bad++;
         $display("FAIL blanked got op=%0b bl=%0b pc=%0d exp op=0 bl=0 pc=6", pix_opaque, pix_blank, pix_piece);
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rom_fill = 2'd1;
      for (int i = 0; i < 64; i++) board_mem[i] = 4'd0;
      board_mem[0]  = 4'h9;
      board_mem[2]  = 4'h6;
      board_mem[63] = 4'hE;
      reset = 1'b1;
      tick(10'd0, 10'd0, 1'b0);
      tick(10'd0, 10'd0, 1'b0);
      reset = 1'b0;
      test_reset;
      test_origin;
      test_col_wrap;
      test_rows;
      test_empty;
      test_opacity;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/board_sprite_sched.md
# board_sprite_sched

Per-pixel scheduler that sequences the shared chess-piece sprite ROM bank for the VGA path. It tracks which board square and which in-square sprite texel the beam is on. Each pixel it fetches the piece code for that square from the board-state RAM, selects the matching 55x55 sprite ROM and issues its address. It returns a pipelined palette index plus overlay flags to the colour mapper. It replaces per-pixel multiply/divide address math with incremental counters.

## Interface
Parameters:
- BOARD_X0, 10'd100: screen X of the board's left edge
- BOARD_Y0, 10'd20: screen Y of the board's top edge
- SQ, 55: square and sprite edge length in pixels

Ports:
- vga_clk  in  1  pixel clock; one DrawX step per cycle during active video
- reset  in  1  asynchronous, active-high reset
- DrawX, DrawY  in  10 each  current beam coordinate
- blank  in  1  1 = active video (draw), 0 = blanking
- sq_index  out  6  board RAM read address {row[2:0], col[2:0]}
- piece_code  in  4  board RAM data, valid 1 cycle after sq_index
- rom_sel  out  4  piece code selecting the sprite ROM (0 = none)
- rom_address  out  12  texel address into the selected ROM
- rom_q  in  2  ROM palette index, valid 1 cycle after rom_address
- pix_index  out  2  palette index for the colour mapper
- pix_piece  out  4  piece code for this pixel (palette-bank select)
- pix_opaque  out  1  piece present and rom_q != 0
- pix_in_board  out  1  pixel lies inside the 8x8 board
- pix_light  out  1  square parity: 1 = light square, (row+col) even
- pix_blank  out  1  blank, delayed to align with the pix_* outputs

## Operation
- Piece encoding: 0 = empty; bit3 = colour (0 white, 1 black); bits[2:0] = 1 pawn … 6 king. Codes 7 and 15 are treated as empty.
- Stage 0, position tracking:
  - x_off (0..SQ-1) and col (0..7):
    - cleared when DrawX == BOARD_X0;
    - otherwise advance by one per cycle;
    - x_off wraps SQ-1→0 and increments col.
  - in_x = 1 from DrawX == BOARD_X0 through BOARD_X0+8*SQ-1.
  - Line-change detect: DrawY differs from the registered DrawY.
    - If DrawY == BOARD_Y0: clear y_off, row and y_base.
    - Otherwise, while in_y: y_off++ and y_base += SQ; when y_off wraps SQ-1→0, clear y_base and increment row.
  - in_y = 1 for DrawY in BOARD_Y0..BOARD_Y0+8*SQ-1.
  - Counters saturate at col/row 7 when the beam leaves the board; they are not used outside the board.
- Stage 1:
  - Drive sq_index = {row, col}.
  - Register addr = y_base + x_off (12-bit; max 54*55+54 = 3024), in_board = in_x & in_y, light = ~(row[0]^col[0]), and blank.
- Stage 2:
  - Drive rom_sel = (in_board && piece_code valid) ? piece_code : 0.
  - Drive rom_address = addr.
  - Carry the flags forward.
- Stage 3:
  - pix_index = rom_q and pix_piece = rom_sel (delayed).
  - pix_opaque = (pix_piece != 0) && (rom_q != 0).
  - Outside the board: pix_piece = 0, pix_opaque = 0, pix_index = 0.
- Blanking does not stall the counters. pix_blank = 0 forces pix_opaque = 0.

## Timing
- Latency is 3 cycles from DrawX/DrawY/blank to all pix_* outputs, fixed with no bubbles. One pixel is accepted every cycle.
- sq_index is registered in the cycle after stage 0. The board RAM must be a 1-cycle synchronous read.
- rom_address and rom_sel are registered. The ROM samples on the negedge and data is consumed at the next posedge.
- Reset (asynchronous):
  - all outputs 0;
  - all counters, y_base and pipeline registers 0;
  - the registered DrawY is 0.
- Reset deasserted mid-frame: outputs are undefined-but-harmless (in_board = 0) until the next DrawY == BOARD_Y0 line. Column tracking is correct from the next DrawX == BOARD_X0.
- Simultaneous DrawX == BOARD_X0 and a line change: both the column and row updates apply in the same cycle.

## Structure
- Shared package chess_pkg:
  - piece_t (4-bit enum);
  - constants SQ_SIZE = 55, BOARD_N = 8, SPRITE_WORDS = 3025;
  - function piece_valid().
- One sub-module, board_pos_tracker: stage-0 counters. Outputs col, row, x_off, y_base, in_x, in_y.
- Pipeline stages 1–3 stay in the top module.

## Test plan
- Reset: assert reset mid-line → all outputs 0 immediately. After release, the first frame starts at DrawY = BOARD_Y0.
- Board origin: drive DrawX = 100, DrawY = 20 with piece_code = 4'h9 (black pawn) → sq_index = 0 at +1 cycle; rom_sel = 9 and rom_address = 0 at +2; pix_piece = 9 at +3.
- Column wrap: DrawX = 154 → rom_address 54, col 0. DrawX = 155 → rom_address 0, sq_index 1, pix_light = 0.
- Line and row advance:
  - DrawY = 21, DrawX = 100 → rom_address 55.
  - DrawY = 75 → rom_address 0, sq_index 8.
  - DrawX = 539, DrawY = 459 → rom_address 3024, sq_index 63.
- Outside and empty:
  - DrawX = 540 → pix_in_board = 0, rom_sel = 0.
  - Empty square (code 0) with rom_q = 2 → pix_opaque = 0.
  - blank = 0 → pix_opaque = 0.
- Opacity: piece 6 with rom_q = 0 → pix_opaque = 0; with rom_q = 3 → pix_opaque = 1, pix_index = 3.
